// File: rtl/ase_pkg.sv
// Shared CCI-P header types for the ASE host-side models, plus the response-queue entry.
package ase_pkg;
  localparam int CCIP_DATA_WIDTH = 512;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd;
    logic [41:0] addr;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } RxHdr_t;

  typedef struct packed {
    logic [41:0] addr;
    logic [15:0] mdata;
    logic [31:0] stamp;
  } rsp_entry_t;
endpackage

// File: rtl/cci_rsp_fifo.sv
// Synchronous FIFO of pending responses; wrap-bit pointers give full/empty/count directly.
module cci_rsp_fifo
  import ase_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_entry_t din,
  input  logic       pop,
  output rsp_entry_t dout,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);
  rsp_entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/cci_rsp_emulator.sv
// Host-side CCI responder: queues rd/wr requests, answers each after a fixed latency with
// mdata echoed, and drives TX almost-full from queue occupancy.
module cci_rsp_emulator
  import ase_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          LATENCY     = 8,
  parameter int          AFULL_SLACK = 4,
  parameter logic [31:0] TS_INIT     = 32'h0,
  localparam int         CW          = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       sys_reset_n,
  input  TxHdr_t                     C0TxHdr,
  input  logic                       C0TxRdValid,
  output logic                       C0TxAlmFull,
  input  TxHdr_t                     C1TxHdr,
  input  logic [CCIP_DATA_WIDTH-1:0] C1TxData,
  input  logic                       C1TxWrValid,
  output logic                       C1TxAlmFull,
  output RxHdr_t                     C0RxHdr,
  output logic [CCIP_DATA_WIDTH-1:0] C0RxData,
  output logic                       C0RxRdValid,
  output RxHdr_t                     C1RxHdr,
  output logic                       C1RxWrValid,
  output logic [CW-1:0]              rd_outstanding,
  output logic [CW-1:0]              wr_outstanding,
  output logic                       overflow_err
);
  // Channel index 0 = read (C0), 1 = write (C1).
  logic [31:0]            tstamp;
  logic [1:0]             reqVld, popReq, pushOk, full, empty, ovfHit, rspVld, almFull;
  rsp_entry_t [1:0]       head, pushEnt;
  logic [1:0][CW-1:0]     cnt, occ;
  logic [1:0][15:0]       rspMdata;
  logic [31:0]            rspData;
  logic                   overflowErr;
  logic                   unusedOk;

  assign reqVld     = {C1TxWrValid, C0TxRdValid};
  assign pushEnt[0] = '{addr: C0TxHdr.addr, mdata: C0TxHdr.mdata, stamp: tstamp};
  assign pushEnt[1] = '{addr: C1TxHdr.addr, mdata: C1TxHdr.mdata, stamp: tstamp};

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) tstamp <= TS_INIT;
    else              tstamp <= tstamp + 32'd1;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [31:0]   age;
    logic [CW-1:0] cntNext;
    logic          rspV, afR;
    logic [15:0]   rspMd;
    logic [CW-1:0] occR;

    // Modular subtraction keeps the age correct across timestamp wrap.
    assign age        = tstamp - head[ch].stamp;
    assign popReq[ch] = !empty[ch] && (age >= 32'(LATENCY - 1));
    // A pop this edge frees a slot, so a push into a full queue still lands.
    assign pushOk[ch] = reqVld[ch] && (!full[ch] || popReq[ch]);
    assign ovfHit[ch] = reqVld[ch] && full[ch] && !popReq[ch];
    assign cntNext    = cnt[ch] + CW'(pushOk[ch]) - CW'(popReq[ch]);

    cci_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (sys_reset_n),
      .push  (pushOk[ch]),
      .din   (pushEnt[ch]),
      .pop   (popReq[ch]),
      .dout  (head[ch]),
      .full  (full[ch]),
      .empty (empty[ch]),
      .count (cnt[ch])
    );

    always_ff @(posedge clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
        rspV  <= 1'b0;
        rspMd <= '0;
        occR  <= '0;
        afR   <= 1'b0;
      end else begin
        rspV <= popReq[ch];
        if (popReq[ch]) rspMd <= head[ch].mdata;
        occR <= cntNext;
        afR  <= (cntNext >= CW'(DEPTH - AFULL_SLACK));
      end
    end

    assign rspVld[ch]   = rspV;
    assign rspMdata[ch] = rspMd;
    assign occ[ch]      = occR;
    assign almFull[ch]  = afR;
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rspData     <= '0;
      overflowErr <= 1'b0;
    end else begin
      if (popReq[0]) rspData <= head[0].addr[31:0];
      overflowErr <= overflowErr | (|ovfHit);
    end
  end

  always_comb begin
    C0RxHdr       = '0;
    C0RxHdr.mdata = rspMdata[0];
    C1RxHdr       = '0;
    C1RxHdr.mdata = rspMdata[1];
  end

  assign C0RxData       = {(CCIP_DATA_WIDTH/32){rspData}};
  assign C0RxRdValid    = rspVld[0];
  assign C1RxWrValid    = rspVld[1];
  assign C0TxAlmFull    = almFull[0];
  assign C1TxAlmFull    = almFull[1];
  assign rd_outstanding = occ[0];
  assign wr_outstanding = occ[1];
  assign overflow_err   = overflowErr;

  // Write data and the header control fields are accepted but carry no meaning here.
  assign unusedOk = ^{C1TxData, C0TxHdr.vc_sel, C0TxHdr.cl_len, C0TxHdr.req_type, C0TxHdr.rsvd,
                      C1TxHdr.vc_sel, C1TxHdr.cl_len, C1TxHdr.req_type, C1TxHdr.rsvd,
                      head[0].addr[41:32], head[1].addr};
endmodule

// File: tb/tb_cci_rsp_emulator.sv
// Randomized scoreboard bench: each accepted request is expected back exactly LATENCY cycles later.
module tb_cci_rsp_emulator;
  import ase_pkg::*;

  localparam int DEPTH = 16, SLACK = 4, LAT = 8, LAT2 = 24;
  localparam int DW = CCIP_DATA_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct {
    int          c;
    int          due;
    logic [41:0] addr;
    logic [15:0] md;
  } exp_t;

  logic clk = 0, rst_n = 0;
  int   cyc = 0, nCmp = 0, nFail = 0;
  int   ovfCyc [2] = '{-1, -1};
  exp_t q [3][$];
  string chn [3] = '{"rd", "wr", "rd2"};

  TxHdr_t          c0h = '0, c1h = '0, h2 = '0, zHdr = '0;
  logic            c0v = 0, c1v = 0, v2 = 0, zBit = 0;
  logic [DW-1:0]   c1d = '0, zData = '0;

  logic            C0TxAlmFull, C1TxAlmFull, C0RxRdValid, C1RxWrValid, overflow_err;
  RxHdr_t          C0RxHdr, C1RxHdr;
  logic [DW-1:0]   C0RxData;
  logic [CW-1:0]   rd_outstanding, wr_outstanding;

  logic            C0TxAlmFull2, C1TxAlmFull2, C0RxRdValid2, C1RxWrValid2, overflow_err2;
  RxHdr_t          C0RxHdr2, C1RxHdr2;
  logic [DW-1:0]   C0RxData2;
  logic [CW-1:0]   rd_outstanding2, wr_outstanding2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cci_rsp_emulator dut (
    .clk(clk), .sys_reset_n(rst_n),
    .C0TxHdr(c0h), .C0TxRdValid(c0v), .C0TxAlmFull(C0TxAlmFull),
    .C1TxHdr(c1h), .C1TxData(c1d), .C1TxWrValid(c1v), .C1TxAlmFull(C1TxAlmFull),
    .C0RxHdr(C0RxHdr), .C0RxData(C0RxData), .C0RxRdValid(C0RxRdValid),
    .C1RxHdr(C1RxHdr), .C1RxWrValid(C1RxWrValid),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .overflow_err(overflow_err)
  );

  // Long latency so the queue can fill; timestamp starts just below the 32-bit wrap.
  cci_rsp_emulator #(.DEPTH(DEPTH), .LATENCY(LAT2), .AFULL_SLACK(SLACK), .TS_INIT(32'hFFFF_FFF0)) dut2 (
    .clk(clk), .sys_reset_n(rst_n),
    .C0TxHdr(h2), .C0TxRdValid(v2), .C0TxAlmFull(C0TxAlmFull2),
    .C1TxHdr(zHdr), .C1TxData(zData), .C1TxWrValid(zBit), .C1TxAlmFull(C1TxAlmFull2),
    .C0RxHdr(C0RxHdr2), .C0RxData(C0RxData2), .C0RxRdValid(C0RxRdValid2),
    .C1RxHdr(C1RxHdr2), .C1RxWrValid(C1RxWrValid2),
    .rd_outstanding(rd_outstanding2), .wr_outstanding(wr_outstanding2),
    .overflow_err(overflow_err2)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [41:0] rnda();
    return {10'($urandom), 32'($urandom)};
  endfunction

  // Queue contents before the next edge, and whether that edge releases the head.
  function automatic bit accepts(input int ch);
    int occ = 0;
    bit popNext = 0;
    for (int i = 0; i < q[ch].size(); i++) begin
      if (q[ch][i].due > cyc) occ++;
      if (q[ch][i].due == cyc + 1) popNext = 1;
    end
    return (occ < DEPTH) || popNext;
  endfunction

  task automatic push(input int ch, input logic [41:0] a, input logic [15:0] m);
    exp_t e;
    int d = (ch == 2) ? 1 : 0;
    if (accepts(ch)) begin
      e.c = cyc; e.due = cyc + ((ch == 2) ? LAT2 : LAT); e.addr = a; e.md = m;
      q[ch].push_back(e);
    end else if (ovfCyc[d] < 0) begin
      ovfCyc[d] = cyc + 1;
    end
  endtask

  task automatic drive(input logic rv, input logic [41:0] ra, input logic [15:0] rm,
                       input logic wv, input logic [41:0] wa, input logic [15:0] wm,
                       input logic v2n, input logic [41:0] a2, input logic [15:0] m2);
    @(posedge clk); #2;
    c0v = rv; c0h = '0; c0h.req_type = 4'($urandom); c0h.addr = ra; c0h.mdata = rm;
    c1v = wv; c1h = '0; c1h.vc_sel = 2'($urandom); c1h.addr = wa; c1h.mdata = wm;
    c1d = {16{$urandom}};
    v2 = v2n; h2 = '0; h2.cl_len = 2'($urandom); h2.addr = a2; h2.mdata = m2;
    if (rv)  push(0, ra, rm);
    if (wv)  push(1, wa, wm);
    if (v2n) push(2, a2, m2);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, '0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic chkResetState();
    chk("rst rdvld", C0RxRdValid, 0);  chk("rst wrvld", C1RxWrValid, 0);
    chk("rst rdhdr", C0RxHdr, 0);      chk("rst wrhdr", C1RxHdr, 0);
    chk("rst data", C0RxData, 0);      chk("rst af0", C0TxAlmFull, 0);
    chk("rst af1", C1TxAlmFull, 0);    chk("rst rdocc", rd_outstanding, 0);
    chk("rst wrocc", wr_outstanding, 0); chk("rst ovf", overflow_err, 0);
    chk("rst2 rdvld", C0RxRdValid2, 0); chk("rst2 rdocc", rd_outstanding2, 0);
    chk("rst2 ovf", overflow_err2, 0);  chk("rst2 af", C0TxAlmFull2, 0);
  endtask

  task automatic check_ch(input int ch, input logic vld, input RxHdr_t hdr, input logic [DW-1:0] data,
                          input bit hasData, input int occAct, input logic af);
    exp_t   e;
    RxHdr_t eh;
    bit     expV = (q[ch].size() > 0) && (q[ch][0].due == cyc);
    int     occ = 0;
    chk({chn[ch], " valid"}, vld, expV);
    if (expV) begin
      e = q[ch].pop_front();
      if (vld) begin
        eh = '0; eh.mdata = e.md;
        chk({chn[ch], " hdr"}, hdr, eh);
        if (hasData) chk({chn[ch], " data"}, data, {(DW/32){e.addr[31:0]}});
      end
    end
    for (int i = 0; i < q[ch].size(); i++)
      if (q[ch][i].c < cyc && q[ch][i].due > cyc) occ++;
    chk({chn[ch], " occupancy"}, occAct, occ);
    chk({chn[ch], " almfull"}, af, occ >= DEPTH - SLACK);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_ch(0, C0RxRdValid,  C0RxHdr,  C0RxData,  1'b1, int'(rd_outstanding),  C0TxAlmFull);
      check_ch(1, C1RxWrValid,  C1RxHdr,  '0,        1'b0, int'(wr_outstanding),  C1TxAlmFull);
      check_ch(2, C0RxRdValid2, C0RxHdr2, C0RxData2, 1'b1, int'(rd_outstanding2), C0TxAlmFull2);
      chk("ovf",  overflow_err,  ovfCyc[0] >= 0 && cyc >= ovfCyc[0]);
      chk("ovf2", overflow_err2, ovfCyc[1] >= 0 && cyc >= ovfCyc[1]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chkResetState();
    #1 rst_n = 1;

    // Fill the long-latency queue: 16 accepted, then drops until the first pop frees a slot.
    for (int i = 0; i < 26; i++) drive(0, '0, '0, 0, '0, '0, 1, rnda(), 16'(i));
    idle(30);

    drive(1, 42'h1000, 16'h5, 0, '0, '0, 0, '0, '0);
    idle(12);
    for (int i = 1; i <= 4; i++) drive(0, '0, '0, 1, rnda(), 16'(i), 0, '0, '0);
    idle(12);
    drive(1, rnda(), 16'hA5A5, 1, rnda(), 16'h5A5A, 0, '0, '0);
    idle(12);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1) == 1, rnda(), 16'($urandom),
            $urandom_range(0, 2) != 0, rnda(), 16'($urandom),
            $urandom_range(0, 7) == 0, rnda(), 16'($urandom));
    idle(30);

    // Reset with reads in flight: nothing may come back afterwards.
    for (int i = 0; i < 3; i++) drive(1, rnda(), 16'(100 + i), 0, '0, '0, 1, rnda(), 16'(i));
    @(posedge clk); #3;
    rst_n = 0;
    c0v = 0; c1v = 0; v2 = 0;
    for (int ch = 0; ch < 3; ch++) q[ch].delete();
    ovfCyc = '{-1, -1};
    #1 chkResetState();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    idle(30);

    // Timestamp restarts just below wrap; these requests straddle it.
    for (int i = 0; i < 24; i++) drive(0, '0, '0, 0, '0, '0, $urandom_range(0, 1) == 1, rnda(), 16'($urandom));
    idle(40);

    for (int ch = 0; ch < 3; ch++) chk({chn[ch], " drained"}, q[ch].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
